// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory operation into a single
// word-aligned data-memory transaction with byte lanes, extension and a bus timeout.
module load_store_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  access_sz,
  input  logic        s_us,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_next;

  logic [CW-1:0] wait_cnt;
  logic [1:0]    sz_q;
  logic [1:0]    lane_q;
  logic          s_us_q;

  logic          aligned;
  logic          one_op;
  logic          accept;
  logic          misalign_ev;
  logic          bad_req;
  logic          timeout;
  logic [3:0]    be_fmt;
  logic [31:0]   wdata_fmt;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  // Lane placement of the incoming request; loads reuse the same byte enables.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = wdata;
    aligned   = 1'b1;
    case (access_sz)
      2'b00: begin
        be_fmt    = 4'b0001 << addr[1:0];
        wdata_fmt = {4{wdata[7:0]}};
        aligned   = 1'b1;
      end
      2'b01: begin
        be_fmt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{wdata[15:0]}};
        aligned   = ~addr[0];
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata;
        aligned   = (addr[1:0] == 2'b00);
      end
    endcase
  end

  assign one_op      = mem_read ^ mem_write;
  assign accept      = (state == IDLE) && start && one_op && aligned;
  assign misalign_ev = (state == IDLE) && start && one_op && !aligned;
  assign bad_req     = (state == IDLE) && start && mem_read && mem_write;
  assign timeout     = (state == ACCESS) && !dmem_ready &&
                       (wait_cnt == CW'(MAX_WAIT - 1));

  assign busy     = (state == ACCESS);
  assign dmem_req = (state == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (dmem_ready || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Extraction of the returned lane using the address captured at start.
  always_comb begin
    byte_sel = dmem_rdata[8*lane_q +: 8];
    half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (sz_q)
      2'b00:   load_ext = s_us_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = s_us_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      sz_q       <= 2'b00;
      lane_q     <= 2'b00;
      s_us_q     <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      misalign   <= 1'b0;
      err        <= 1'b0;
    end else begin
      done     <= (state == ACCESS) && dmem_ready;
      misalign <= misalign_ev;
      err      <= bad_req || timeout;

      if (accept) begin
        sz_q       <= access_sz;
        lane_q     <= addr[1:0];
        s_us_q     <= s_us;
        dmem_we    <= mem_write;
        dmem_addr  <= {addr[31:2], 2'b00};
        dmem_wdata <= wdata_fmt;
        dmem_be    <= be_fmt;
      end

      if ((state == ACCESS) && dmem_ready && !dmem_we)
        load_data <= load_ext;

      // Counts cycles already spent waiting; cleared whenever the access ends.
      if ((state == ACCESS) && (state_next == ACCESS))
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized operations
// checked against a byte-arithmetic model of lane placement and extension.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  access_sz;
  logic        s_us;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .access_sz(access_sz), .s_us(s_us), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .load_data(load_data),
    .misalign(misalign), .err(err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sizes in bytes and plain arithmetic on byte positions.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic su,
                                             input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    logic [63:0] v;
    logic [63:0] mask;
    if (n == 4) return rd;
    v    = {32'h0, rd} >> (8 * (a % 4));
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!su && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic su, input logic [31:0] a, input logic [31:0] w);
    start = 1'b1; mem_read = rd; mem_write = wr;
    access_sz = sz; s_us = su; addr = a; wdata = w;
  endtask

  task automatic clear_op();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_op(); dmem_ready = 1'b0; dmem_rdata = '0;
    access_sz = 2'b00; s_us = 1'b0; addr = '0; wdata = '0;
    #12;
    total++;
    if ({busy, done, misalign, err, dmem_req, dmem_we} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got %b exp 000000", {busy, done, misalign, err, dmem_req, dmem_we});
    end
    total++;
    if (load_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_load got %h exp 0", load_data); end
    total++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_be !== 4'h0) begin
      bad++; $display("[TB] FAIL reset_bus got %h/%h/%b exp 0", dmem_addr, dmem_wdata, dmem_be);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    drive_op(1, 0, 2'b00, 0, 32'h1003, 32'h0);
    tick(); clear_op();
    total++;
    if (!(dmem_req === 1'b1 && busy === 1'b1 && dmem_we === 1'b0)) begin
      bad++; $display("[TB] FAIL lb_req got req=%b busy=%b we=%b exp 1 1 0", dmem_req, busy, dmem_we);
    end
    total++;
    if (dmem_addr !== 32'h1000 || dmem_be !== 4'b1000) begin
      bad++; $display("[TB] FAIL lb_bus got %h %b exp 00001000 1000", dmem_addr, dmem_be);
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h80FF_1234;
    tick(); dmem_ready = 1'b0;
    total++;
    if (!(done === 1'b1 && busy === 1'b0 && dmem_req === 1'b0)) begin
      bad++; $display("[TB] FAIL lb_done got done=%b busy=%b req=%b exp 1 0 0", done, busy, dmem_req);
    end
    total++;
    if (load_data !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_data got %h exp ffffff80", load_data); end
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL lb_pulse got %b exp 0", done); end
  endtask

  task automatic test_lhu_sh();
    drive_op(1, 0, 2'b01, 1, 32'h2002, 32'h0);
    tick(); clear_op();
    dmem_ready = 1'b1; dmem_rdata = 32'hBEEF_0000;
    tick(); dmem_ready = 1'b0;
    total++;
    if (load_data !== 32'h0000_BEEF || done !== 1'b1) begin
      bad++; $display("[TB] FAIL lhu got %h done=%b exp 0000beef 1", load_data, done);
    end
    tick();
    drive_op(0, 1, 2'b01, 0, 32'h2002, 32'h1234_ABCD);
    tick(); clear_op();
    total++;
    if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || dmem_we !== 1'b1) begin
      bad++; $display("[TB] FAIL sh_bus got %b %h we=%b exp 1100 abcdabcd 1", dmem_be, dmem_wdata, dmem_we);
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_1111;
    tick(); dmem_ready = 1'b0;
    total++;
    if (done !== 1'b1 || load_data !== 32'h0000_BEEF) begin
      bad++; $display("[TB] FAIL sh_hold got done=%b %h exp 1 0000beef", done, load_data);
    end
    tick();
  endtask

  task automatic test_misalign_err();
    int req_seen = 0;
    drive_op(1, 0, 2'b10, 0, 32'h3002, 32'h0);
    tick(); clear_op();
    total++;
    if (!(misalign === 1'b1 && busy === 1'b0 && dmem_req === 1'b0 && err === 1'b0)) begin
      bad++; $display("[TB] FAIL lw_misalign got mis=%b busy=%b req=%b err=%b exp 1 0 0 0", misalign, busy, dmem_req, err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dmem_req || busy || misalign) req_seen++;
    end
    total++;
    if (req_seen != 0) begin bad++; $display("[TB] FAIL misalign_after got %0d activity cycles exp 0", req_seen); end
    drive_op(1, 1, 2'b10, 0, 32'h3000, 32'h0);
    tick(); clear_op();
    total++;
    if (!(err === 1'b1 && misalign === 1'b0 && dmem_req === 1'b0)) begin
      bad++; $display("[TB] FAIL both_err got err=%b mis=%b req=%b exp 1 0 0", err, misalign, dmem_req);
    end
    tick();
    drive_op(0, 0, 2'b10, 0, 32'h3001, 32'h0);
    tick(); clear_op();
    total++;
    if ({err, misalign, dmem_req, busy} !== 4'b0) begin
      bad++; $display("[TB] FAIL none_ignored got %b exp 0000", {err, misalign, dmem_req, busy});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    drive_op(0, 1, 2'b10, 0, 32'h0000_0040, 32'hCAFE_F00D);
    tick(); clear_op();
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      if (err !== 1'b0) break;
      tick();
    end
    total++;
    if (n != 16) begin bad++; $display("[TB] FAIL timeout_len got %0d exp 16", n); end
    total++;
    if (!(err === 1'b1 && done === 1'b0 && busy === 1'b0)) begin
      bad++; $display("[TB] FAIL timeout_err got err=%b done=%b busy=%b exp 1 0 0", err, done, busy);
    end
    tick();
    drive_op(0, 1, 2'b10, 0, 32'h0000_0040, 32'hCAFE_F00D);
    tick(); clear_op();
    for (int i = 1; i < 16; i++) tick();
    total++;
    if (dmem_req !== 1'b1) begin bad++; $display("[TB] FAIL last_wait_req got %b exp 1", dmem_req); end
    dmem_ready = 1'b1;
    tick(); dmem_ready = 1'b0;
    total++;
    if (!(done === 1'b1 && err === 1'b0)) begin
      bad++; $display("[TB] FAIL ready_wins got done=%b err=%b exp 1 0", done, err);
    end
    tick();
    total++;
    if (err !== 1'b0) begin bad++; $display("[TB] FAIL ready_wins_late got err=%b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    int unstable = 0;
    int extra = 0;
    drive_op(0, 1, 2'b00, 0, 32'h0000_0055, 32'h0000_00A7);
    tick();
    drive_op(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (dmem_addr !== 32'h54 || dmem_be !== 4'b0010 || dmem_wdata !== 32'hA7A7_A7A7 ||
          dmem_req !== 1'b1) unstable++;
      tick();
    end
    clear_op();
    if (dmem_addr !== 32'h54 || dmem_be !== 4'b0010 || dmem_wdata !== 32'hA7A7_A7A7) unstable++;
    total++;
    if (unstable != 0) begin bad++; $display("[TB] FAIL stall_stable got %0d bad cycles exp 0", unstable); end
    dmem_ready = 1'b1;
    tick(); dmem_ready = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL stall_done got %b exp 1", done); end
    for (int i = 0; i < 4; i++) begin
      if (dmem_req || busy) extra++;
      tick();
    end
    total++;
    if (extra != 0) begin bad++; $display("[TB] FAIL busy_start_ignored got %0d cycles exp 0", extra); end

    drive_op(1, 0, 2'b10, 0, 32'h0000_0200, 32'h0);
    tick(); clear_op();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, misalign, err, dmem_req, dmem_we, dmem_be} !== 10'b0 ||
        dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || load_data !== 32'h0) begin
      bad++; $display("[TB] FAIL mid_reset got busy=%b req=%b addr=%h ld=%h exp all 0", busy, dmem_req, dmem_addr, load_data);
    end
    #3; rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || err || busy || dmem_req) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("[TB] FAIL after_reset got %0d active cycles exp 0", extra); end
  endtask

  task automatic test_random();
    logic [31:0] exp_load = 32'h0;
    for (int it = 0; it < 60; it++) begin
      logic        is_load = $urandom_range(0, 1);
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        su = 1'($urandom_range(0, 1));
      logic [31:0] a = $urandom;
      logic [31:0] w = $urandom;
      logic [31:0] rd = $urandom;
      int          dly = $urandom_range(0, 4);
      if ($urandom_range(0, 2) != 0) a[1:0] = (sz == 2'b00) ? a[1:0] : (sz == 2'b01) ? {a[1], 1'b0} : 2'b00;
      drive_op(is_load, !is_load, sz, su, a, w);
      tick(); clear_op();
      if ((a % nbytes(sz)) != 0) begin
        total++;
        if (!(misalign === 1'b1 && dmem_req === 1'b0)) begin
          bad++; $display("[TB] FAIL rnd_misalign it=%0d got mis=%b req=%b exp 1 0", it, misalign, dmem_req);
        end
        tick();
        continue;
      end
      total++;
      if (dmem_req !== 1'b1 || dmem_addr !== {a[31:2], 2'b00} || dmem_be !== model_be(sz, a) ||
          dmem_we !== !is_load) begin
        bad++; $display("[TB] FAIL rnd_bus it=%0d got %h %b we=%b exp %h %b we=%b", it,
                        dmem_addr, dmem_be, dmem_we, {a[31:2], 2'b00}, model_be(sz, a), !is_load);
      end
      if (!is_load) begin
        total++;
        if (dmem_wdata !== model_wdata(sz, w)) begin
          bad++; $display("[TB] FAIL rnd_wdata it=%0d got %h exp %h", it, dmem_wdata, model_wdata(sz, w));
        end
      end
      for (int d = 0; d < dly; d++) tick();
      dmem_ready = 1'b1; dmem_rdata = rd;
      tick(); dmem_ready = 1'b0;
      if (is_load) exp_load = model_load(sz, su, a, rd);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || load_data !== exp_load) begin
        bad++; $display("[TB] FAIL rnd_done it=%0d got done=%b ld=%h exp 1 %h", it, done, load_data, exp_load);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_sh();
    test_misalign_err();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
